spi_cmd_scheduler: RTL and testbench
====================================

Name: spi_cmd_scheduler

Overview:
- Sits between the SPI communication layer and the beam-scanner core.
- Turns completed SPI register frames (address byte plus 16-bit value) into single-cycle config-register writes.
- Also sequences read-back streams. It drives the send-data-mode line, feeds one byte per SPI segment from a sample source, and counts down a requested length.
- Runs entirely in the system clock domain and resynchronizes the SPI-side completion strobe.

Parameters:
CFG_ADDR_MAX, 8'h07, highest writable config address; addresses 8'h01..CFG_ADDR_MAX are config writes.
STREAM_ADDR, 8'h80, address that starts a read-back stream.
LEN_W, 16, width of the stream byte counter; the length comes from reg_value[LEN_W-1:0].
UNDERRUN_BYTE, 8'h00, byte sent when the source has no data ready.
TIMEOUT_CYCLES, 1000000, watchdog limit (used only with the optional feature).

Ports:
clk  in  1  system clock.
rstb  in  1  asynchronous, active-low reset.
xfer_done  in  1  completion strobe from the SPI comm layer; asynchronous to clk.
reg_addr  in  8  frame address; stable while xfer_done is high.
reg_value  in  16  frame value; stable while xfer_done is high.
cfg_we  out  1  one-cycle config write strobe.
cfg_addr  out  8  config write address.
cfg_wdata  out  16  config write data.
send_mode  out  1  drives the comm layer's SendDataMode.
tx_byte  out  8  byte presented to the comm layer's DataOut.
src_valid  in  1  sample source has a byte.
src_data  in  8  sample source byte.
src_ready  out  1  pop strobe; a byte is consumed when src_valid && src_ready.
busy  out  1  high in any state other than IDLE.
err_cnt  out  8  count of invalid-address frames; saturates at 8'hFF.
underrun  out  1  sticky flag; cleared by a write to address 8'h00.

Behaviour:
- Reset (rstb low, asynchronous):
  - All outputs go to 0; tx_byte goes to 0.
  - FSM goes to IDLE; stream counter goes to 0; synchronizer flops are cleared.
  - A reset mid-stream aborts the stream immediately with send_mode=0.
- Synchronizer:
  - xfer_done passes through 2 flops, then rising-edge detection produces the event `ev`.
  - ev fires 3 clk cycles after xfer_done rises.
  - reg_addr and reg_value are sampled into holding registers on the ev cycle.
- FSM states: IDLE, WRITE, LOAD, SEND, DONE.
- IDLE, on ev:
  - addr == 8'h00: no-op. Clears underrun. Stays in IDLE.
  - 8'h01 <= addr <= CFG_ADDR_MAX: go to WRITE.
  - addr == STREAM_ADDR with length 0: ignored. Stays in IDLE; no error counted.
  - addr == STREAM_ADDR with length != 0: load the counter with the length, set send_mode=1, go to LOAD.
  - Any other address: err_cnt += 1 (saturating). Stays in IDLE.
- WRITE:
  - cfg_we=1 for exactly one cycle, with cfg_addr/cfg_wdata taken from the holding registers.
  - Next state is IDLE.
  - cfg_addr/cfg_wdata hold their last values afterwards.
  - Write latency is 4 clk from the xfer_done rise.
- LOAD:
  - If src_valid: src_ready=1 for that one cycle and tx_byte <= src_data.
  - If !src_valid: tx_byte <= UNDERRUN_BYTE and underrun <= 1.
  - Either way, go to SEND next cycle. LOAD never waits.
- SEND: waits for ev, which means the byte has shifted out. On ev, decrement the counter.
  - Counter becomes 0: go to DONE.
  - Otherwise: go to LOAD.
- DONE: send_mode <= 0, then IDLE. Exactly one cycle.
- While send_mode=1, ev is treated only as a byte-shifted event. reg_addr is ignored and no config writes or errors occur.
- src_ready is never high outside LOAD and is never high for 2 consecutive cycles.
- A counter loaded with N yields exactly N ev events and N LOAD visits.
- The counter is LEN_W bits and is never decremented below 0.
- xfer_done held high for many cycles produces one ev only. A second event needs a low period of at least 2 clk.

Optional Feature:
STREAM_TIMEOUT_EN:
- Defined:
  - A cycle counter runs in SEND and is cleared on every ev and on SEND entry.
  - On reaching TIMEOUT_CYCLES-1 the FSM goes to DONE (send_mode drops), and err_cnt += 1 (saturating).
- Undefined: no watchdog; SEND waits indefinitely.

Test Plan:
- Frame addr=8'h03, value=16'hBEEF -> cfg_we high exactly 1 cycle, 4 clk after xfer_done rises, with cfg_addr=8'h03 and cfg_wdata=16'hBEEF; busy high for 1 cycle.
- Frames addr=8'h40, then 8'hFF, then 8'h00 -> err_cnt=2; no cfg_we; underrun stays 0.
- addr=8'h80, value=3, src_valid=1 with bytes A1/A2/A3 -> send_mode=1; tx_byte sequence A1, A2, A3 before each of 3 events; 3 src_ready pulses; send_mode=0 one cycle after the 3rd event.
- addr=8'h80, value=2, src_valid=0 -> tx_byte=8'h00 twice; underrun=1 after the stream; a following addr=8'h00 frame -> underrun=0.
- Mid-stream (value=5, after 2 events): rstb low -> send_mode=0, busy=0, tx_byte=0 immediately. After release, a config write frame works normally.
- With STREAM_TIMEOUT_EN and TIMEOUT_CYCLES=100: start a stream and send no events -> send_mode falls after about 100 clk; err_cnt=1.

Source files
------------

// File: rtl/spi_cmd_scheduler_if.sv
// Bus bundle between the SPI command scheduler and its neighbours: the SPI comm layer's frame
// and strobe lines, the config-register write port, the stream byte path and status outputs.
interface spi_cmd_scheduler_if;
  logic        xfer_done;
  logic [7:0]  reg_addr;
  logic [15:0] reg_value;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        send_mode;
  logic [7:0]  tx_byte;
  logic        src_valid;
  logic [7:0]  src_data;
  logic        src_ready;
  logic        busy;
  logic [7:0]  err_cnt;
  logic        underrun;

  // Environment side: the SPI comm layer, the sample source and the config register file.
  modport master (
    output xfer_done, reg_addr, reg_value, src_valid, src_data,
    input  cfg_we, cfg_addr, cfg_wdata, send_mode, tx_byte, src_ready, busy, err_cnt, underrun
  );

  // Scheduler side.
  modport slave (
    input  xfer_done, reg_addr, reg_value, src_valid, src_data,
    output cfg_we, cfg_addr, cfg_wdata, send_mode, tx_byte, src_ready, busy, err_cnt, underrun
  );
endinterface

// File: rtl/spi_cmd_scheduler.sv
// Turns SPI register frames into config writes and sequences read-back byte streams.
// Optional stream watchdog enabled by defining STREAM_TIMEOUT_EN.
module spi_cmd_scheduler #(
  parameter logic [7:0]  CFG_ADDR_MAX   = 8'h07,
  parameter logic [7:0]  STREAM_ADDR    = 8'h80,
  parameter int unsigned LEN_W          = 16,
  parameter logic [7:0]  UNDERRUN_BYTE  = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic                clk,
  input logic                rstb,
  spi_cmd_scheduler_if.slave bus
);

  if (TIMEOUT_CYCLES < 2 || LEN_W < 1 || LEN_W > 16) begin : g_param_check
    $error("spi_cmd_scheduler: unsupported parameter values");
  end

  typedef enum logic [2:0] {StIdle, StWrite, StLoad, StSend, StDone} state_e;

  state_e             state_q, state_d;
  logic               sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d, ev_q, ev_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         hold_addr_q, hold_addr_d;
  logic [15:0]        hold_value_q, hold_value_d;
  logic [7:0]         cfg_addr_q, cfg_addr_d;
  logic [15:0]        cfg_wdata_q, cfg_wdata_d;
  logic               send_mode_q, send_mode_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               underrun_q, underrun_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic               err_inc;
  logic               tmo_hit;

  // Two-flop resync of the SPI-side strobe, then a registered rising-edge detector.
  always_comb begin
    sync1_d = bus.xfer_done;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    ev_d    = sync2_q & ~sync3_q;
  end

`ifdef STREAM_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TmoW-1:0] tmo_q, tmo_d;

  // Counts idle SEND cycles; zero outside SEND so every SEND entry starts fresh.
  always_comb begin
    tmo_d = '0;
    if (state_q == StSend && !ev_q) tmo_d = tmo_q + 1'b1;
  end

  assign tmo_hit = (state_q == StSend) && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold_addr_d   = hold_addr_q;
    hold_value_d  = hold_value_q;
    cfg_addr_d    = cfg_addr_q;
    cfg_wdata_d   = cfg_wdata_q;
    send_mode_d   = send_mode_q;
    tx_byte_d     = tx_byte_q;
    underrun_d    = underrun_q;
    err_inc       = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.src_ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ev_q) begin
          hold_addr_d  = bus.reg_addr;
          hold_value_d = bus.reg_value;
          if (bus.reg_addr == 8'h00) begin
            underrun_d = 1'b0;
          end else if (bus.reg_addr <= CFG_ADDR_MAX) begin
            state_d = StWrite;
          end else if (bus.reg_addr == STREAM_ADDR) begin
            if (bus.reg_value[LEN_W-1:0] != '0) begin
              cnt_d       = bus.reg_value[LEN_W-1:0];
              send_mode_d = 1'b1;
              state_d     = StLoad;
            end
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      StWrite: begin
        bus.cfg_we  = 1'b1;
        cfg_addr_d  = hold_addr_q;
        cfg_wdata_d = hold_value_q;
        state_d     = StIdle;
      end
      StLoad: begin
        if (bus.src_valid) begin
          bus.src_ready = 1'b1;
          tx_byte_d     = bus.src_data;
        end else begin
          tx_byte_d  = UNDERRUN_BYTE;
          underrun_d = 1'b1;
        end
        state_d = StSend;
      end
      StSend: begin
        if (ev_q) begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          if (cnt_q <= LEN_W'(1)) begin
            // send_mode drops as DONE is entered so the comm layer sees it one cycle after ev.
            send_mode_d = 1'b0;
            state_d     = StDone;
          end else begin
            state_d = StLoad;
          end
        end else if (tmo_hit) begin
          send_mode_d = 1'b0;
          err_inc     = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        send_mode_d = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    err_cnt_d = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= StIdle;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      ev_q         <= 1'b0;
      cnt_q        <= '0;
      hold_addr_q  <= '0;
      hold_value_q <= '0;
      cfg_addr_q   <= '0;
      cfg_wdata_q  <= '0;
      send_mode_q  <= 1'b0;
      tx_byte_q    <= '0;
      underrun_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
      ev_q         <= ev_d;
      cnt_q        <= cnt_d;
      hold_addr_q  <= hold_addr_d;
      hold_value_q <= hold_value_d;
      cfg_addr_q   <= cfg_addr_d;
      cfg_wdata_q  <= cfg_wdata_d;
      send_mode_q  <= send_mode_d;
      tx_byte_q    <= tx_byte_d;
      underrun_q   <= underrun_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // During WRITE the holding registers are presented directly; afterwards the last write holds.
  assign bus.cfg_addr  = (state_q == StWrite) ? hold_addr_q : cfg_addr_q;
  assign bus.cfg_wdata = (state_q == StWrite) ? hold_value_q : cfg_wdata_q;
  assign bus.send_mode = send_mode_q;
  assign bus.tx_byte   = tx_byte_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.err_cnt   = err_cnt_q;
  assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Self-checking bench for spi_cmd_scheduler: frame vector table, hand-written stream
// sequences, randomized frames/streams against a transaction-level model, reset and timeout.
module tb_spi_cmd_scheduler;
  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  spi_cmd_scheduler_if bus ();

  spi_cmd_scheduler #(
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk (clk),
    .rstb(rstb),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level model of the architectural state.
  logic [7:0]  m_err;
  logic        m_under;
  logic [7:0]  m_cfg_addr;
  logic [15:0] m_cfg_wdata;

  // Stimulus source and per-frame observations.
  logic [7:0]  src_q[$];
  logic [7:0]  m_src[$];
  logic        pop_pending;
  logic        prev_ready;
  logic        prev_mode;
  int          ready_pulses;
  int          cyc;
  int          we_cnt;
  int          we_lat;
  logic [7:0]  we_addr;
  logic [15:0] we_data;
  int          busy_cycles;
  int          fall_cyc;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] value;
    int          exp_we;
    logic [7:0]  exp_err;
    logic [7:0]  exp_cfg_addr;
    logic [15:0] exp_cfg_wdata;
    int          exp_busy;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; observe 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pop_pending) begin
      if (src_q.size() != 0) void'(src_q.pop_front());
      pop_pending = 1'b0;
    end
    bus.src_data = (src_q.size() != 0) ? src_q[0] : 8'h5A;
    if (bus.src_ready) begin
      ready_pulses++;
      check("src_ready_back_to_back", {31'd0, prev_ready}, 32'd0);
      check("src_ready_without_valid", {31'd0, bus.src_valid}, 32'd1);
      pop_pending = 1'b1;
    end
    prev_ready = bus.src_ready;
    if (prev_mode && !bus.send_mode) fall_cyc = cyc;
    prev_mode = bus.send_mode;
    if (bus.cfg_we) begin
      we_cnt++;
      if (we_cnt == 1) begin
        we_lat  = cyc;
        we_addr = bus.cfg_addr;
        we_data = bus.cfg_wdata;
      end
    end
    if (bus.busy) busy_cycles++;
  endtask

  task automatic send_frame(input logic [7:0] addr, input logic [15:0] value, input int hold);
    bus.reg_addr  = addr;
    bus.reg_value = value;
    we_cnt        = 0;
    busy_cycles   = 0;
    cyc           = 0;
    fall_cyc      = -1;
    bus.xfer_done = 1'b1;
    repeat (hold) tick();
    bus.xfer_done = 1'b0;
    repeat (4) tick();
  endtask

  // Model of a single frame seen while idle.
  task automatic model_frame(input logic [7:0] addr, input logic [15:0] value);
    if (addr == 8'h00) begin
      m_under = 1'b0;
    end else if (addr <= 8'h07) begin
      m_cfg_addr  = addr;
      m_cfg_wdata = value;
    end else if (addr == 8'h80 && value == 16'h0000) begin
      m_err = m_err;
    end else if (m_err != 8'hFF) begin
      m_err = m_err + 8'd1;
    end
  endtask

  task automatic checked_frame(input logic [7:0] addr, input logic [15:0] value);
    int exp_we;
    exp_we = (addr >= 8'h01 && addr <= 8'h07) ? 1 : 0;
    model_frame(addr, value);
    send_frame(addr, value, 6);
    check("rnd_we_count", we_cnt, exp_we);
    if (exp_we == 1) check("rnd_we_latency", we_lat, 4);
    check("rnd_err_cnt", bus.err_cnt, m_err);
    check("rnd_underrun", {31'd0, bus.underrun}, {31'd0, m_under});
    check("rnd_cfg_addr", bus.cfg_addr, m_cfg_addr);
    check("rnd_cfg_wdata", bus.cfg_wdata, m_cfg_wdata);
  endtask

  // Stream of len bytes; valid_bits[i] is the source's src_valid during the i-th byte load.
  task automatic run_stream(input int len, input logic [31:0] valid_bits);
    logic [7:0] exp_byte;
    int exp_pulses;
    int we_total;
    m_src        = src_q;
    exp_pulses   = 0;
    we_total     = 0;
    ready_pulses = 0;
    bus.src_valid = valid_bits[0];
    send_frame(8'h80, len[15:0], 2);
    we_total += we_cnt;
    check("stream_mode_on", {31'd0, bus.send_mode}, 32'd1);
    for (int i = 0; i < len; i++) begin
      if (valid_bits[i]) begin
        exp_byte = m_src.pop_front();
        exp_pulses++;
      end else begin
        exp_byte = 8'h00;
        m_under  = 1'b1;
      end
      check("stream_tx_byte", bus.tx_byte, exp_byte);
      check("stream_mode_held", {31'd0, bus.send_mode}, 32'd1);
      if (i + 1 < len) bus.src_valid = valid_bits[i+1];
      // The address is ignored while streaming; an invalid one must not count as an error.
      send_frame(8'h40, 16'h1234, 2);
      we_total += we_cnt;
    end
    check("stream_mode_fall_cycle", fall_cyc, 4);
    check("stream_ready_pulses", ready_pulses, exp_pulses);
    check("stream_no_cfg_we", we_total, 0);
    check("stream_busy_end", {31'd0, bus.busy}, 32'd0);
    check("stream_err_cnt", bus.err_cnt, m_err);
    check("stream_underrun", {31'd0, bus.underrun}, {31'd0, m_under});
    bus.src_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_err       = '0;
    m_under     = 1'b0;
    m_cfg_addr  = '0;
    m_cfg_wdata = '0;
    src_q.delete();
    pop_pending = 1'b0;
    prev_ready  = 1'b0;
    prev_mode   = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h03, 16'hBEEF, 1, 8'd0, 8'h03, 16'hBEEF, 1};
    vecs[1] = '{8'h40, 16'h1234, 0, 8'd1, 8'h03, 16'hBEEF, 0};
    vecs[2] = '{8'hFF, 16'h0000, 0, 8'd2, 8'h03, 16'hBEEF, 0};
    vecs[3] = '{8'h00, 16'h5555, 0, 8'd2, 8'h03, 16'hBEEF, 0};
    vecs[4] = '{8'h07, 16'h0001, 1, 8'd2, 8'h07, 16'h0001, 1};
    vecs[5] = '{8'h08, 16'hFFFF, 0, 8'd3, 8'h07, 16'h0001, 0};
    vecs[6] = '{8'h01, 16'hA5A5, 1, 8'd3, 8'h01, 16'hA5A5, 1};
    vecs[7] = '{8'h80, 16'h0000, 0, 8'd3, 8'h01, 16'hA5A5, 0};

    rstb          = 1'b0;
    bus.xfer_done = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_value = '0;
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    model_reset();
    cyc = 0;
    repeat (3) tick();
    rstb = 1'b1;
    tick();

    check("reset_cfg_we", {31'd0, bus.cfg_we}, 32'd0);
    check("reset_send_mode", {31'd0, bus.send_mode}, 32'd0);
    check("reset_tx_byte", bus.tx_byte, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_err_cnt", bus.err_cnt, 32'd0);
    check("reset_underrun", {31'd0, bus.underrun}, 32'd0);
    check("reset_src_ready", {31'd0, bus.src_ready}, 32'd0);
    check("reset_cfg_addr", bus.cfg_addr, 32'd0);

    // Frame vector table.
    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].addr, vecs[v].value, 6);
      check("vec_we_count", we_cnt, vecs[v].exp_we);
      if (vecs[v].exp_we == 1) begin
        check("vec_we_latency", we_lat, 4);
        check("vec_we_addr", we_addr, vecs[v].exp_cfg_addr);
        check("vec_we_data", we_data, vecs[v].exp_cfg_wdata);
      end
      check("vec_busy_cycles", busy_cycles, vecs[v].exp_busy);
      check("vec_err_cnt", bus.err_cnt, vecs[v].exp_err);
      check("vec_underrun", {31'd0, bus.underrun}, 32'd0);
      check("vec_cfg_addr_hold", bus.cfg_addr, vecs[v].exp_cfg_addr);
      check("vec_cfg_wdata_hold", bus.cfg_wdata, vecs[v].exp_cfg_wdata);
      model_frame(vecs[v].addr, vecs[v].value);
    end

    // Stream of three bytes from a ready source.
    src_q.delete();
    src_q.push_back(8'hA1);
    src_q.push_back(8'hA2);
    src_q.push_back(8'hA3);
    bus.src_data = src_q[0];
    run_stream(3, 32'h7);

    // Underrun stream, then clear via address 0.
    run_stream(2, 32'h0);
    check("underrun_set", {31'd0, bus.underrun}, 32'd1);
    checked_frame(8'h00, 16'h0000);
    check("underrun_cleared", {31'd0, bus.underrun}, 32'd0);

    // Randomized mix of frames and streams.
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        int len;
        len = int'($urandom_range(1, 4));
        src_q.delete();
        for (int b = 0; b < len; b++) src_q.push_back(8'($urandom));
        bus.src_data = src_q[0];
        run_stream(len, $urandom);
      end else begin
        logic [7:0]  a;
        logic [15:0] d;
        a = 8'($urandom_range(0, 255));
        d = 16'($urandom);
        if (a == 8'h80) d = 16'h0000;
        checked_frame(a, d);
      end
    end

    // Error counter saturation.
    for (int k = 0; k < 260; k++) begin
      model_frame(8'hF0, 16'h0000);
      send_frame(8'hF0, 16'h0000, 2);
    end
    check("err_cnt_saturated", bus.err_cnt, 32'hFF);
    check("err_cnt_model_sat", bus.err_cnt, m_err);

    // Asynchronous reset in the middle of a five-byte stream.
    src_q.delete();
    for (int b = 0; b < 5; b++) src_q.push_back(8'hC0 + 8'(b));
    bus.src_data  = src_q[0];
    bus.src_valid = 1'b1;
    send_frame(8'h80, 16'd5, 2);
    send_frame(8'h40, 16'h0000, 2);
    send_frame(8'h40, 16'h0000, 2);
    check("midstream_mode_before_reset", {31'd0, bus.send_mode}, 32'd1);
    #3;
    rstb = 1'b0;
    #1;
    check("midreset_send_mode", {31'd0, bus.send_mode}, 32'd0);
    check("midreset_busy", {31'd0, bus.busy}, 32'd0);
    check("midreset_tx_byte", bus.tx_byte, 32'd0);
    check("midreset_err_cnt", bus.err_cnt, 32'd0);
    bus.src_valid = 1'b0;
    model_reset();
    tick();
    rstb = 1'b1;
    tick();
    send_frame(8'h05, 16'hCAFE, 6);
    check("post_reset_we_count", we_cnt, 1);
    check("post_reset_we_latency", we_lat, 4);
    check("post_reset_we_addr", we_addr, 32'h05);
    check("post_reset_we_data", we_data, 32'hCAFE);

`ifdef STREAM_TIMEOUT_EN
    begin
      int n;
      n = 0;
      src_q.delete();
      src_q.push_back(8'h77);
      bus.src_data  = src_q[0];
      bus.src_valid = 1'b1;
      send_frame(8'h80, 16'd1, 2);
      while (bus.send_mode && n < 300) begin
        tick();
        n++;
      end
      check("timeout_mode_dropped", {31'd0, bus.send_mode}, 32'd0);
      check("timeout_window", {31'd0, (n >= 90 && n <= 110)}, 32'd1);
      model_frame(8'hF0, 16'h0000);
      check("timeout_err_cnt", bus.err_cnt, m_err);
      bus.src_valid = 1'b0;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
